// File: rtl/vs_residual_updater.sv
// Matching-pursuit residual update: r[i] <= r[i] - coef*phi[i][k] for the selected atom,
// streamed one element per cycle through the residual RAM, with residual energy accumulation.
//
// state  | meaning
// IDLE   | waiting for start; addresses hold their last value
// READ   | issuing phi/residual read addresses, one element per cycle
// DRAIN  | last element is written back
// FINISH | one-cycle done pulse; a new start is accepted here too
module vs_residual_updater #(
    parameter int ROWS           = 4,
    parameter int COLUMNS        = 8,
    parameter int NORM_SHIFT     = 2,
    parameter int DATA_WIDTH     = 32,
    parameter int RES_ADDR_WIDTH = 8,
    parameter int PHI_ADDR_WIDTH = 16
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic [7:0]                atom_index,
    input  logic [DATA_WIDTH-1:0]     atom_value,
    output logic [PHI_ADDR_WIDTH-1:0] phi_read_addr,
    input  logic [DATA_WIDTH-1:0]     phi_read_data,
    output logic [RES_ADDR_WIDTH-1:0] res_read_addr,
    input  logic [DATA_WIDTH-1:0]     res_read_data,
    output logic                      res_write_enable,
    output logic [RES_ADDR_WIDTH-1:0] res_write_addr,
    output logic [DATA_WIDTH-1:0]     res_write_data,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic [63:0]               residual_energy
);

    localparam int CW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [7:0]    COLS_P   = 8'(COLUMNS);
    localparam logic [CW-1:0] LAST_ROW = CW'(ROWS - 1);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_FINISH} state_t;

    state_t                       state_q;
    logic [7:0]                   k_q;
    logic signed [DATA_WIDTH-1:0] coef_q;
    logic [CW-1:0]                count_q;
    logic                         valid_q;
    logic [RES_ADDR_WIDTH-1:0]    waddr_q;
    logic                         busy_q;
    logic                         done_q;
    logic                         error_q;
    logic [63:0]                  energy_q;

    logic [DATA_WIDTH-1:0] prod;
    logic [DATA_WIDTH-1:0] diff;
    logic [63:0]           diff_ext;
    logic [63:0]           sq;

    // Only the low DATA_WIDTH bits of the product matter, so the wrap is intentional.
    always_comb begin
        prod     = coef_q * phi_read_data;
        diff     = res_read_data - prod;
        diff_ext = 64'($signed(diff));
        sq       = diff_ext * diff_ext;
    end

    assign phi_read_addr    = PHI_ADDR_WIDTH'(k_q) * PHI_ADDR_WIDTH'(ROWS) + PHI_ADDR_WIDTH'(count_q);
    assign res_read_addr    = RES_ADDR_WIDTH'(count_q);
    assign res_write_enable = valid_q;
    assign res_write_addr   = waddr_q;
    assign res_write_data   = valid_q ? diff : '0;
    assign busy             = busy_q;
    assign done             = done_q;
    assign error            = error_q;
    assign residual_energy  = energy_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            k_q      <= '0;
            coef_q   <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            waddr_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            energy_q <= '0;
        end else begin
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            if (valid_q) begin
                energy_q <= energy_q + sq;
            end
            case (state_q)
                S_IDLE, S_FINISH: begin
                    state_q <= S_IDLE;
                    if (start) begin
                        if (atom_index < COLS_P) begin
                            k_q      <= atom_index;
                            coef_q   <= $signed(atom_value) >>> NORM_SHIFT;
                            count_q  <= '0;
                            energy_q <= '0;
                            error_q  <= 1'b0;
                            busy_q   <= 1'b1;
                            state_q  <= S_READ;
                        end else begin
                            // Bad column: report through done/error without touching the RAM.
                            error_q <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= S_FINISH;
                        end
                    end
                end
                S_READ: begin
                    valid_q <= 1'b1;
                    waddr_q <= RES_ADDR_WIDTH'(count_q);
                    if (count_q == LAST_ROW) begin
                        state_q <= S_DRAIN;
                    end else begin
                        count_q <= count_q + CW'(1);
                    end
                end
                S_DRAIN: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= S_FINISH;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vs_residual_updater.sv
// Randomised and directed bench for vs_residual_updater with behavioural RAMs and a
// plain-arithmetic residual/energy reference model.
module tb_vs_residual_updater;

    localparam int ROWS = 4;
    localparam int COLS = 8;
    localparam int NORM = 2;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic [7:0]  atom_index;
    logic [31:0] atom_value;
    logic [15:0] phi_read_addr;
    logic [31:0] phi_read_data;
    logic [7:0]  res_read_addr;
    logic [31:0] res_read_data;
    logic        res_write_enable;
    logic [7:0]  res_write_addr;
    logic [31:0] res_write_data;
    logic        busy;
    logic        done;
    logic        error;
    logic [63:0] residual_energy;

    int n_chk  = 0;
    int n_pass = 0;

    int phi_mem [0:ROWS*COLS-1];
    int res_mem [0:255];
    int model_r [0:ROWS-1];
    int wr_q [$];

    always #5 clock = ~clock;

    vs_residual_updater dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .start            (start),
        .atom_index       (atom_index),
        .atom_value       (atom_value),
        .phi_read_addr    (phi_read_addr),
        .phi_read_data    (phi_read_data),
        .res_read_addr    (res_read_addr),
        .res_read_data    (res_read_data),
        .res_write_enable (res_write_enable),
        .res_write_addr   (res_write_addr),
        .res_write_data   (res_write_data),
        .busy             (busy),
        .done             (done),
        .error            (error),
        .residual_energy  (residual_energy)
    );

    always @(posedge clock) begin
        phi_read_data <= (phi_read_addr < 16'(ROWS*COLS)) ? phi_mem[phi_read_addr] : 0;
        res_read_data <= res_mem[res_read_addr];
        if (res_write_enable) begin
            res_mem[res_write_addr] <= res_write_data;
            wr_q.push_back(int'(res_write_addr));
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic load_res(input int a, input int b, input int c, input int d);
        res_mem[0] = a; res_mem[1] = b; res_mem[2] = c; res_mem[3] = d;
        for (int i = 0; i < ROWS; i++) model_r[i] = res_mem[i];
    endtask

    // Issue one start (caller is mid-cycle) and follow the run to its done pulse.
    task automatic run(input int idx, input int val, input bit noise, output longint exp_e);
        int  c;
        int  n;
        bit  ok;
        ok    = idx < COLS;
        c     = val >>> NORM;
        exp_e = 0;
        if (ok) begin
            for (int i = 0; i < ROWS; i++) begin
                model_r[i] = model_r[i] - c * phi_mem[idx*ROWS + i];
                exp_e += longint'(model_r[i]) * longint'(model_r[i]);
            end
        end
        wr_q.delete();
        start = 1'b1; atom_index = 8'(idx); atom_value = val;
        @(posedge clock); #1;
        start = 1'b0; atom_index = 8'($urandom); atom_value = $urandom;
        check("busy_after_start", busy, ok);
        n = 0;
        while (!done && n < 20) begin
            if (noise && n == 2) begin
                start = 1'b1; atom_index = 8'($urandom_range(0, 9)); atom_value = $urandom;
            end
            if (n == 3) start = 1'b0;
            @(posedge clock); #1;
            n++;
            if (ok && n == ROWS) check("busy_mid", busy, 1);
        end
        check("done_latency", n, ok ? ROWS + 1 : 0);
        check("busy_at_done", busy, 0);
        check("error", error, !ok);
        check("wr_count", wr_q.size(), ok ? ROWS : 0);
        for (int i = 0; i < wr_q.size(); i++) check("wr_addr", wr_q[i], i);
        for (int i = 0; i < ROWS; i++) check("ram", res_mem[i], model_r[i]);
        if (ok) check("energy", residual_energy, exp_e);
    endtask

    initial begin
        longint e;
        int     exp_a [0:ROWS-1];
        reset_n = 1'b0; start = 1'b0; atom_index = '0; atom_value = '0;
        for (int i = 0; i < ROWS*COLS; i++) phi_mem[i] = $urandom_range(0, 20) - 10;
        for (int i = 0; i < 256; i++) res_mem[i] = 0;
        for (int i = 0; i < ROWS; i++) begin
            phi_mem[i] = 1;
            phi_mem[7*ROWS + i] = 1;
        end
        phi_mem[7*ROWS] = -1;
        repeat (3) @(posedge clock);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_wen", res_write_enable, 0);
        check("rst_energy", residual_energy, 0);
        @(negedge clock) reset_n = 1'b1;
        @(negedge clock);

        load_res(-1, -2, -2, 1);
        run(0, -4, 0, e);
        check("dir0_energy", residual_energy, 6);
        exp_a = '{0, -1, -1, 2};
        for (int i = 0; i < ROWS; i++) check("dir0_ram", res_mem[i], exp_a[i]);

        @(negedge clock);
        load_res(-1, -2, -2, 1);
        run(7, -2, 0, e);
        check("dir7_energy", residual_energy, 10);
        exp_a = '{-2, -1, -1, 2};
        for (int i = 0; i < ROWS; i++) check("dir7_ram", res_mem[i], exp_a[i]);

        @(negedge clock);
        load_res(-1, -2, -2, 1);
        run(8, 5, 0, e);

        // Reset dropped right after the second write of an index-0 run.
        @(negedge clock);
        load_res(-1, -2, -2, 1);
        start = 1'b1; atom_index = 8'd0; atom_value = -4;
        @(posedge clock); #1; start = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b0;
        #1;
        check("rstrun_wen", res_write_enable, 0);
        check("rstrun_wdata", res_write_data, 0);
        check("rstrun_busy", busy, 0);
        check("rstrun_done", done, 0);
        check("rstrun_error", error, 0);
        check("rstrun_energy", residual_energy, 0);
        check("rstrun_addr", {phi_read_addr, res_read_addr, res_write_addr}, 0);
        @(negedge clock) reset_n = 1'b1;
        @(negedge clock);
        exp_a = '{0, -1, -2, 1};
        for (int i = 0; i < ROWS; i++) check("rstrun_ram", res_mem[i], exp_a[i]);

        // Back-to-back: second start lands in the done cycle of the first.
        @(negedge clock);
        load_res(-1, -2, -2, 1);
        run(0, -4, 1, e);
        run(7, 8, 1, e);
        check("b2b_energy", residual_energy, 22);
        exp_a = '{2, -3, -3, 0};
        for (int i = 0; i < ROWS; i++) check("b2b_ram", res_mem[i], exp_a[i]);

        @(negedge clock);
        load_res(-1, -2, -2, 1);
        run(3, 0, 0, e);
        check("zero_energy", residual_energy, 10);

        for (int t = 0; t < 40; t++) begin
            int v;
            if ($urandom_range(0, 2) != 0) @(negedge clock);
            if (!busy && !done) begin
                for (int i = 0; i < ROWS*COLS; i++)
                    phi_mem[i] = ($urandom_range(0, 3) == 0) ? int'($urandom) : $urandom_range(0, 200) - 100;
                load_res(int'($urandom), $urandom_range(0, 2000) - 1000,
                         $urandom_range(0, 2000) - 1000, int'($urandom));
            end
            v = ($urandom_range(0, 1) == 0) ? int'($urandom) : $urandom_range(0, 40) - 20;
            run($urandom_range(0, 9), v, 1'($urandom), e);
        end

        repeat (2) @(negedge clock);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
